// File: rtl/dvp_raw_capture.sv
// -----------------------------------------------------------------------------
// dvp_raw_capture
//
// Camera front end for the OV5640 DVP bus. Vsync/Href/Dvp_Data are registered
// once (stage 1). The qualified pixel stream is produced from that stage
// (stage 2). A pixel presented on Dvp_Data in cycle N is sampled at edge N+1.
// It appears on Raw_Data with Dout_Valid at edge N+2.
//
// After reset the first SKIP_FRAMES frames are discarded. A frame boundary is
// the rising edge of the registered Vsync. Capture_En is looked at only on
// those boundaries.
//
// Within a captured frame, the block counts columns and rows. Pixels past
// IMAGE_WIDTH and lines past IMAGE_HEIGHT are dropped. Short or long lines,
// and a wrong line count, raise the sticky Line_Err flag. Line_Err is cleared
// by the next Frame_Start.
//
// Ports
//   Clk          pixel clock (DVP PCLK); all logic on the rising edge
//   Rst          synchronous active-high reset
//   Vsync        DVP vertical sync, high during vertical blanking
//   Href         DVP line valid
//   Dvp_Data     8-bit RAW Bayer byte
//   Capture_En   capture request, sampled at frame boundaries only
//   Dout_Valid   Raw_Data / Xaddr / Yaddr / X_Cnt / Y_Cnt valid this cycle
//   Raw_Data     captured Bayer pixel (held when not valid)
//   Xaddr        column LSB of the presented pixel (Bayer phase)
//   Yaddr        row LSB of the presented pixel (Bayer phase)
//   X_Cnt        column index of the presented pixel
//   Y_Cnt        row index of the presented pixel
//   Frame_Start  1-cycle pulse, a captured frame begins
//   Frame_Done   1-cycle pulse, a captured frame ended
//   Line_Err     sticky line length / line count error for the current frame
// -----------------------------------------------------------------------------
module dvp_raw_capture #(
    parameter int IMAGE_WIDTH  = 1920,
    parameter int IMAGE_HEIGHT = 1080,
    parameter int SKIP_FRAMES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Vsync,
    input  logic        Href,
    input  logic [7:0]  Dvp_Data,
    input  logic        Capture_En,
    output logic        Dout_Valid,
    output logic [7:0]  Raw_Data,
    output logic        Xaddr,
    output logic        Yaddr,
    output logic [11:0] X_Cnt,
    output logic [11:0] Y_Cnt,
    output logic        Frame_Start,
    output logic        Frame_Done,
    output logic        Line_Err
);

    localparam logic [11:0] WIDTH   = 12'(IMAGE_WIDTH);
    localparam logic [11:0] HEIGHT  = 12'(IMAGE_HEIGHT);
    localparam logic [7:0]  SKIP_N  = 8'(SKIP_FRAMES);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        ST_SKIP  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (SKIP_FRAMES == 0) ? ST_IDLE : ST_SKIP;

    // Stage 1: input capture
    logic        vs_r_reg;
    logic        vs_rr_reg;
    logic        hr_r_reg;
    logic [7:0]  data_r_reg;
    logic        hr_act_d_reg;

    // Control state
    state_t      state_reg,    state_next;
    logic [7:0]  skip_cnt_reg, skip_cnt_next;
    logic [11:0] x_reg,        x_next;
    logic [11:0] y_reg,        y_next;
    logic        err_reg,      err_next;

    // Stage 2: output registers
    logic        valid_reg,    valid_next;
    logic [7:0]  raw_reg,      raw_next;
    logic [11:0] xcnt_reg,     xcnt_next;
    logic [11:0] ycnt_reg,     ycnt_next;
    logic        start_reg,    start_next;
    logic        done_reg,     done_next;

    logic boundary;
    logic hr_act;
    logic line_end;

    assign boundary = vs_r_reg & ~vs_rr_reg;
    // Href during vertical blanking is ignored: it neither delivers pixels nor
    // terminates a line.
    assign hr_act   = hr_r_reg & ~vs_r_reg;
    assign line_end = hr_act_d_reg & ~hr_act;

    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        err_next      = err_reg;
        valid_next    = 1'b0;
        raw_next      = raw_reg;
        xcnt_next     = xcnt_reg;
        ycnt_next     = ycnt_reg;
        start_next    = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            ST_SKIP: begin
                if (boundary) begin
                    skip_cnt_next = skip_cnt_reg + 8'd1;
                    if (skip_cnt_reg + 8'd1 >= SKIP_N) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                if (boundary && Capture_En) begin
                    state_next = ST_FRAME;
                    start_next = 1'b1;
                    x_next     = '0;
                    y_next     = '0;
                    err_next   = 1'b0;
                end
            end

            ST_FRAME: begin
                if (hr_act) begin
                    if ((x_reg < WIDTH) && (y_reg < HEIGHT)) begin
                        valid_next = 1'b1;
                        raw_next   = data_r_reg;
                        xcnt_next  = x_reg;
                        ycnt_next  = y_reg;
                    end else begin
                        err_next = 1'b1;
                    end
                    // Keep counting past the width so an over-long line
                    // also fails the end-of-line length compare.
                    if (x_reg != CNT_MAX) begin
                        x_next = x_reg + 12'd1;
                    end
                end

                if (line_end) begin
                    if (x_reg != WIDTH) begin
                        err_next = 1'b1;
                    end
                    x_next = '0;
                    if (y_reg != CNT_MAX) begin
                        y_next = y_reg + 12'd1;
                    end
                end

                if (boundary) begin
                    done_next = 1'b1;
                    if (y_reg != HEIGHT) begin
                        err_next = 1'b1;
                    end
                    if (Capture_En) begin
                        // Back-to-back frame: the restart clears the flag,
                        // overriding any error detected in this cycle.
                        start_next = 1'b1;
                        x_next     = '0;
                        y_next     = '0;
                        err_next   = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            vs_r_reg     <= 1'b0;
            vs_rr_reg    <= 1'b0;
            hr_r_reg     <= 1'b0;
            data_r_reg   <= '0;
            hr_act_d_reg <= 1'b0;
            state_reg    <= RESET_STATE;
            skip_cnt_reg <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            err_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            raw_reg      <= '0;
            xcnt_reg     <= '0;
            ycnt_reg     <= '0;
            start_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            vs_r_reg     <= Vsync;
            vs_rr_reg    <= vs_r_reg;
            hr_r_reg     <= Href;
            data_r_reg   <= Dvp_Data;
            hr_act_d_reg <= hr_act;
            state_reg    <= state_next;
            skip_cnt_reg <= skip_cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            err_reg      <= err_next;
            valid_reg    <= valid_next;
            raw_reg      <= raw_next;
            xcnt_reg     <= xcnt_next;
            ycnt_reg     <= ycnt_next;
            start_reg    <= start_next;
            done_reg     <= done_next;
        end
    end

    assign Dout_Valid  = valid_reg;
    assign Raw_Data    = raw_reg;
    assign X_Cnt       = xcnt_reg;
    assign Y_Cnt       = ycnt_reg;
    assign Xaddr       = xcnt_reg[0];
    assign Yaddr       = ycnt_reg[0];
    assign Frame_Start = start_reg;
    assign Frame_Done  = done_reg;
    assign Line_Err    = err_reg;

endmodule

// File: tb/tb_dvp_raw_capture.sv
// -----------------------------------------------------------------------------
// tb_dvp_raw_capture
//
// Bench for dvp_raw_capture with IMAGE_WIDTH=4, IMAGE_HEIGHT=2 and
// SKIP_FRAMES=2.
//
// The stimulus pushes expected pixels and expected frame events into queues.
// A monitor on the falling clock edge pops an entry whenever the DUT presents
// a pixel or a frame pulse, and compares it. A few level checks cover reset,
// latency and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_dvp_raw_capture;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int SKIP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic [7:0]  dvp_data;
    logic        capture_en;
    logic        dout_valid;
    logic [7:0]  raw_data;
    logic        xaddr;
    logic        yaddr;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;

    always #5 clk = ~clk;

    dvp_raw_capture #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Vsync      (vsync),
        .Href       (href),
        .Dvp_Data   (dvp_data),
        .Capture_En (capture_en),
        .Dout_Valid (dout_valid),
        .Raw_Data   (raw_data),
        .Xaddr      (xaddr),
        .Yaddr      (yaddr),
        .X_Cnt      (x_cnt),
        .Y_Cnt      (y_cnt),
        .Frame_Start(frame_start),
        .Frame_Done (frame_done),
        .Line_Err   (line_err)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic [11:0] x;
        logic [11:0] y;
    } pix_t;

    typedef struct packed {
        logic s;
        logic d;
        logic e;
    } evt_t;

    pix_t pix_q[$];
    evt_t evt_q[$];
    pix_t pe;
    evt_t ee;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents output.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got data %0h x %0d y %0d, required none",
                         raw_data, x_cnt, y_cnt);
            end else begin
                pe = pix_q.pop_front();
                check("pixel {data,x,y,xaddr,yaddr}",
                      64'({raw_data, x_cnt, y_cnt, xaddr, yaddr}),
                      64'({pe.d, pe.x, pe.y, pe.x[0], pe.y[0]}));
            end
        end
        if (frame_start === 1'b1 || frame_done === 1'b1) begin
            if (evt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_event: got start %0b done %0b err %0b, required none",
                         frame_start, frame_done, line_err);
            end else begin
                ee = evt_q.pop_front();
                check("frame_event {start,done,line_err}",
                      64'({frame_start, frame_done, line_err}),
                      64'({ee.s, ee.d, ee.e}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input logic s, input logic d, input logic e);
        evt_t ev;
        ev.s = s;
        ev.d = d;
        ev.e = e;
        evt_q.push_back(ev);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Drives npix pixels base, base+1, ... and expects the first nexp of them
    // on row 'row'. With lat_chk set, the first pixel's latency is checked.
    task automatic drive_line(input int npix, input int nexp, input int row,
                              input logic [7:0] base, input bit lat_chk);
        pix_t p;
        for (int i = 0; i < npix; i++) begin
            href     = 1'b1;
            dvp_data = base + 8'(i);
            if (i < nexp) begin
                p.d = base + 8'(i);
                p.x = 12'(i);
                p.y = 12'(row);
                pix_q.push_back(p);
            end
            tick();
            if (lat_chk && i == 0) check("latency_edge_n1_not_valid", 64'(dout_valid), 64'(0));
            if (lat_chk && i == 1) check("latency_edge_n2 {valid,data}",
                                         64'({dout_valid, raw_data}), 64'({1'b1, base}));
        end
        href     = 1'b0;
        dvp_data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, 64'({dout_valid, raw_data, xaddr, yaddr, x_cnt, y_cnt,
                          frame_start, frame_done, line_err}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        vsync      = 1'b0;
        href       = 1'b0;
        dvp_data   = 8'h00;
        capture_en = 1'b1;
        repeat (4) tick();
        check_outputs_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) tick();

        // Test 1: two skipped frames, then capture on the third boundary.
        for (int f = 0; f < SKIP; f++) begin
            vsync_pulse();
            drive_line(4, 0, 0, 8'h10, 1'b0);
            drive_line(4, 0, 1, 8'h14, 1'b0);
        end
        push_evt(1'b1, 1'b0, 1'b0);
        vsync_pulse();
        // Test 2: latency of the first captured pixel (A5).
        drive_line(4, 4, 0, 8'hA5, 1'b1);
        drive_line(4, 4, 1, 8'h30, 1'b0);
        check("clean_frame_line_err", 64'(line_err), 64'(0));

        // Test 3: over-long line; extra pixels dropped, sticky error.
        push_evt(1'b1, 1'b1, 1'b0);
        vsync_pulse();
        drive_line(6, 4, 0, 8'h40, 1'b0);
        check("long_line_sets_line_err", 64'(line_err), 64'(1));
        drive_line(4, 4, 1, 8'h50, 1'b0);
        check("line_err_sticky", 64'(line_err), 64'(1));
        push_evt(1'b1, 1'b1, 1'b0);
        vsync_pulse();
        check("frame_start_clears_line_err", 64'(line_err), 64'(0));

        // Test 4: only one line in the frame; reported at the boundary.
        drive_line(4, 4, 0, 8'h60, 1'b0);
        check("no_err_before_boundary", 64'(line_err), 64'(0));
        capture_en = 1'b0;
        push_evt(1'b0, 1'b1, 1'b1);
        vsync_pulse();
        check("short_frame_line_err_held", 64'(line_err), 64'(1));
        drive_line(4, 0, 0, 8'h68, 1'b0);
        drive_line(4, 0, 1, 8'h6C, 1'b0);
        capture_en = 1'b1;
        push_evt(1'b1, 1'b0, 1'b0);
        vsync_pulse();
        check("restart_clears_line_err", 64'(line_err), 64'(0));

        // Test 5: Capture_En dropped mid-frame; frame still completes.
        drive_line(4, 4, 0, 8'h70, 1'b0);
        capture_en = 1'b0;
        drive_line(4, 4, 1, 8'h78, 1'b0);
        push_evt(1'b0, 1'b1, 1'b0);
        vsync_pulse();
        drive_line(4, 0, 0, 8'h80, 1'b0);
        drive_line(4, 0, 1, 8'h84, 1'b0);
        capture_en = 1'b1;
        push_evt(1'b1, 1'b0, 1'b0);
        vsync_pulse();

        // Test 6: reset mid-line. Only the pixel already in stage 2 emerges.
        begin
            pix_t p;
            href     = 1'b1;
            dvp_data = 8'h91;
            p.d = 8'h91;
            p.x = 12'd0;
            p.y = 12'd0;
            pix_q.push_back(p);
            tick();
            dvp_data = 8'h92;
            tick();
            rst      = 1'b1;
            dvp_data = 8'h93;
            tick();
            check_outputs_zero("mid_line_reset_outputs");
            href     = 1'b0;
            dvp_data = 8'h00;
            repeat (2) tick();
            rst = 1'b0;
            repeat (2) tick();
        end
        for (int f = 0; f < SKIP; f++) begin
            vsync_pulse();
            drive_line(4, 0, 0, 8'hB0, 1'b0);
            drive_line(4, 0, 1, 8'hB4, 1'b0);
        end
        push_evt(1'b1, 1'b0, 1'b0);
        vsync_pulse();
        drive_line(4, 4, 0, 8'hC0, 1'b0);
        drive_line(4, 4, 1, 8'hC8, 1'b0);
        capture_en = 1'b0;
        push_evt(1'b0, 1'b1, 1'b0);
        vsync_pulse();
        repeat (5) tick();

        check("pixel_queue_drained", 64'(pix_q.size()), 64'(0));
        check("event_queue_drained", 64'(evt_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
